// File: rtl/fuzzy_rules_seq.sv
// fuzzy_rules_seq: sequential NT x ND fuzzy rule evaluator.
// One rule is evaluated per cycle. Each rule strength is aggregated by max
// into the consequent class chosen by a runtime rule map. The strongest
// single rule and its index are tracked alongside the aggregation.
// Optional macro FUZZY_PROD_AND_EN selects the algebraic-product AND
// (upper half of the 2W-bit product). The default AND is unsigned min.
module fuzzy_rules_seq #(
    parameter int W  = 16,
    parameter int NT = 3,
    parameter int ND = 3,
    parameter int NC = 3,
    localparam int CW  = (NC > 1) ? $clog2(NC) : 1,
    localparam int NR  = NT * ND,
    localparam int RW  = (NR > 1) ? $clog2(NR) : 1,
    localparam int TIW = (NT > 1) ? $clog2(NT) : 1,
    localparam int DJW = (ND > 1) ? $clog2(ND) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NT*W-1:0]  muT,
    input  logic [ND*W-1:0]  muD,
    input  logic [NR*CW-1:0] rule_map,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NC*W-1:0]  w_cons,
    output logic [W-1:0]     w_max,
    output logic [RW-1:0]    win_idx,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   r_q;
    logic [TIW-1:0]  i_q;
    logic [DJW-1:0]  j_q;
    logic [W-1:0]    mut_q [NT];
    logic [W-1:0]    mud_q [ND];
    logic [CW-1:0]   map_q [NR];
    logic [W-1:0]    acc_q [NC];
    logic [W-1:0]    wmax_q;
    logic [RW-1:0]   win_q;

    logic            accept;
    logic            eval;
    logic            last_rule;
    logic [W-1:0]    t_deg;
    logic [W-1:0]    d_deg;
    logic [W-1:0]    s;
    logic [CW-1:0]   cls;

    assign accept    = in_valid && (state_q == S_IDLE);
    assign eval      = (state_q == S_EVAL);
    assign last_rule = (r_q == RW'(NR - 1));

    assign t_deg = mut_q[i_q];
    assign d_deg = mud_q[j_q];
    assign cls   = map_q[r_q];

`ifdef FUZZY_PROD_AND_EN
    logic [2*W-1:0] prod;
    assign prod = {{W{1'b0}}, t_deg} * {{W{1'b0}}, d_deg};
    assign s    = prod[2*W-1:W];
`else
    assign s = (t_deg < d_deg) ? t_deg : d_deg;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: accept -> walk all rules -> hold result until taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)  state_d = S_EVAL;
            S_EVAL:  if (last_rule) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE:  in_ready = 1'b1;
            S_EVAL:  busy = 1'b1;
            S_DONE:  begin out_valid = 1'b1; busy = 1'b1; end
            default: in_ready = 1'b0;
        endcase
    end

    // Rule counter, kept as flat index plus (i, j) to avoid a divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
            i_q <= '0;
            j_q <= '0;
        end else if (accept) begin
            r_q <= '0;
            i_q <= '0;
            j_q <= '0;
        end else if (eval && !last_rule) begin
            r_q <= r_q + 1'b1;
            if (j_q == DJW'(ND - 1)) begin
                j_q <= '0;
                i_q <= i_q + 1'b1;
            end else begin
                j_q <= j_q + 1'b1;
            end
        end
    end

    genvar gi;

    generate
        for (gi = 0; gi < NT; gi++) begin : g_mut
            // Latch temperature degree gi at accept
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)      mut_q[gi] <= '0;
                else if (accept) mut_q[gi] <= muT[gi*W +: W];
            end
        end

        for (gi = 0; gi < ND; gi++) begin : g_mud
            // Latch delta degree gi at accept
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)      mud_q[gi] <= '0;
                else if (accept) mud_q[gi] <= muD[gi*W +: W];
            end
        end

        for (gi = 0; gi < NR; gi++) begin : g_map
            // Latch rule-map entry gi at accept
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)      map_q[gi] <= '0;
                else if (accept) map_q[gi] <= rule_map[gi*CW +: CW];
            end
        end

        for (gi = 0; gi < NC; gi++) begin : g_acc
            // Max-aggregate into class gi; out-of-range map entries match no class
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    acc_q[gi] <= '0;
                else if (accept)
                    acc_q[gi] <= '0;
                else if (eval && (cls == CW'(gi)) && (s > acc_q[gi]))
                    acc_q[gi] <= s;
            end
            assign w_cons[gi*W +: W] = acc_q[gi];
        end
    endgenerate

    // Strongest rule tracker; strict compare keeps the lowest index on ties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wmax_q <= '0;
            win_q  <= '0;
        end else if (accept) begin
            wmax_q <= '0;
            win_q  <= '0;
        end else if (eval && (s > wmax_q)) begin
            wmax_q <= s;
            win_q  <= r_q;
        end
    end

    assign w_max   = wmax_q;
    assign win_idx = win_q;

endmodule

// File: tb/tb_fuzzy_rules_seq.sv
// Testbench for fuzzy_rules_seq: scoreboard of expected results pushed at
// accept and popped when the block presents out_valid.
module tb_fuzzy_rules_seq;

    localparam int W  = 16;
    localparam int NT = 3;
    localparam int ND = 3;
    localparam int NC = 3;
    localparam int CW = 2;
    localparam int NR = 9;
    localparam int RW = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [NT*W-1:0]  muT = '0;
    logic [ND*W-1:0]  muD = '0;
    logic [NR*CW-1:0] rule_map = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [NC*W-1:0]  w_cons;
    logic [W-1:0]     w_max;
    logic [RW-1:0]    win_idx;
    logic             busy;

    fuzzy_rules_seq #(.W(W), .NT(NT), .ND(ND), .NC(NC)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .muT(muT), .muD(muD), .rule_map(rule_map),
        .out_valid(out_valid), .out_ready(out_ready),
        .w_cons(w_cons), .w_max(w_max), .win_idx(win_idx), .busy(busy)
    );

    typedef struct packed {
        logic [NC*W-1:0] cons;
        logic [W-1:0]    wmax;
        logic [RW-1:0]   idx;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_hs_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [NT*W-1:0] mt, input logic [ND*W-1:0] md,
                                   input logic [NR*CW-1:0] mp);
        exp_t e;
        logic [W-1:0]   a, b, s;
        logic [2*W-1:0] p;
        int c, r;
        e = '0;
        for (int i = 0; i < NT; i++) begin
            for (int j = 0; j < ND; j++) begin
                a = mt[i*W +: W];
                b = md[j*W +: W];
`ifdef FUZZY_PROD_AND_EN
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                s = p[2*W-1:W];
`else
                p = '0;
                s = (a < b) ? a : b;
`endif
                r = i * ND + j;
                c = int'(mp[r*CW +: CW]);
                if (c < NC && s > e.cons[c*W +: W]) e.cons[c*W +: W] = s;
                if (s > e.wmax) begin
                    e.wmax = s;
                    e.idx  = RW'(r);
                end
            end
        end
        return e;
    endfunction

    function automatic logic [3*W-1:0] p3(input logic [W-1:0] a, b, c);
        return {c, b, a};
    endfunction

    function automatic logic [NR*CW-1:0] map_ri();
        logic [NR*CW-1:0] m;
        m = '0;
        for (int r = 0; r < NR; r++) m[r*CW +: CW] = CW'(r / ND);
        return m;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge
    task automatic send(input logic [NT*W-1:0] mt, input logic [ND*W-1:0] md,
                        input logic [NR*CW-1:0] mp, input bit hold, output int acc_cyc);
        int n;
        in_valid = 1'b1;
        muT = mt;
        muD = md;
        rule_map = mp;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%b required 1 within 200 cycles", in_ready);
        end else begin
            sb.push_back(model(mt, md, mp));
        end
        acc_cyc = cyc;
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    // Waits for out_valid, checks against the scoreboard, optionally stalls
    task automatic collect(input string name, input int stall, input bit drop_after,
                           output int out_cyc);
        int n;
        exp_t e;
        n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        out_cyc = cyc;
        n_checks++;
        if (!out_valid || sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s_out_timeout: out_valid=%b sb=%0d required valid result", name,
                     out_valid, sb.size());
        end else begin
            e = sb.pop_front();
            $display("txn %s: cyc=%0d w_cons=%h w_max=%h win_idx=%0d", name, cyc, w_cons, w_max,
                     win_idx);
            n_checks++;
            if (w_cons !== e.cons) begin
                n_fail++;
                $display("FAIL %s_w_cons: got %h required %h", name, w_cons, e.cons);
            end
            n_checks++;
            if (w_max !== e.wmax) begin
                n_fail++;
                $display("FAIL %s_w_max: got %h required %h", name, w_max, e.wmax);
            end
            n_checks++;
            if (win_idx !== e.idx) begin
                n_fail++;
                $display("FAIL %s_win_idx: got %0d required %0d", name, win_idx, e.idx);
            end
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                n_checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
                    w_cons !== e.cons || w_max !== e.wmax || win_idx !== e.idx) begin
                    n_fail++;
                    $display("FAIL %s_stall_stable: k=%0d ov=%b ir=%b busy=%b w_cons=%h w_max=%h idx=%0d required 1 0 1 %h %h %0d",
                             name, k, out_valid, in_ready, busy, w_cons, w_max, win_idx,
                             e.cons, e.wmax, e.idx);
                end
            end
        end
        out_ready = 1'b1;
        last_hs_cyc = cyc;
        @(negedge clk);
        if (drop_after) out_ready = 1'b0;
    endtask

    task automatic check_reset_vals(input string name);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            w_cons !== '0 || w_max !== '0 || win_idx !== '0) begin
            n_fail++;
            $display("FAIL %s: ir=%b ov=%b busy=%b w_cons=%h w_max=%h idx=%0d required 1 0 0 0 0 0",
                     name, in_ready, out_valid, busy, w_cons, w_max, win_idx);
        end
    endtask

    task automatic test_reset();
        int a;
        int seen;
        repeat (3) @(negedge clk);
        check_reset_vals("reset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("reset_idle");
        out_ready = 1'b1;
        send(p3(16'h9000, 16'h7000, 16'h5000), p3(16'h8000, 16'h6000, 16'h4000), map_ri(), 1'b0, a);
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_eval_busy: got %b required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        check_reset_vals("reset_mid_eval");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_no_partial: out_valid cycles=%0d required 0", seen);
        end
    endtask

    task automatic test_basic_min();
        int a, o;
        out_ready = 1'b1;
        send(p3(16'h8000, 16'h4000, 16'h0000), p3(16'h6000, 16'hFFFF, 16'h0000), map_ri(), 1'b0, a);
        collect("basic", 0, 1'b0, o);
        n_checks++;
        if (o - a != 10) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d required 10", o - a);
        end
`ifndef FUZZY_PROD_AND_EN
        n_checks++;
        if (w_cons !== p3(16'h8000, 16'h4000, 16'h0000) || w_max !== 16'h8000 || win_idx !== 4'd1) begin
            n_fail++;
            $display("FAIL basic_const: w_cons=%h w_max=%h idx=%0d required 000040008000 8000 1",
                     w_cons, w_max, win_idx);
        end
`endif
    endtask

    task automatic test_tie_ignored();
        int a, o;
        logic [NR*CW-1:0] m;
        m = '0;
        m[0 +: CW] = 2'd3;
        send({3{16'h1234}}, {3{16'h1234}}, m, 1'b0, a);
        collect("tie_ignored", 0, 1'b0, o);
    endtask

    task automatic test_backpressure();
        int a, o, b, ob;
        out_ready = 1'b0;
        send(p3(16'h2000, 16'hA000, 16'h3000), p3(16'h5000, 16'h1000, 16'hC000), map_ri(), 1'b0, a);
        fork
            send(p3(16'h0100, 16'h0200, 16'h0300), p3(16'h0300, 16'h0200, 16'h0100), map_ri(),
                 1'b0, b);
            collect("bp_first", 20, 1'b1, o);
        join
        n_checks++;
        if (b != last_hs_cyc + 1) begin
            n_fail++;
            $display("FAIL bp_accept_cycle: got %0d required %0d", b, last_hs_cyc + 1);
        end
        out_ready = 1'b1;
        collect("bp_second", 0, 1'b0, ob);
    endtask

    task automatic test_back_to_back();
        int a1, a2, o1, o2;
        out_ready = 1'b1;
        fork
            begin
                send(p3(16'hF000, 16'h0F00, 16'h00F0), p3(16'hFFFF, 16'hFFFF, 16'hFFFF), map_ri(),
                     1'b1, a1);
                send(p3(16'h0010, 16'h0020, 16'h0030), p3(16'h0005, 16'h0040, 16'h0001), map_ri(),
                     1'b0, a2);
            end
            begin
                collect("b2b_first", 0, 1'b0, o1);
                collect("b2b_second", 0, 1'b0, o2);
            end
        join
        n_checks++;
        if (o2 - o1 != 11) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d required 11", o2 - o1);
        end
        n_checks++;
        if (a2 - a1 != 11) begin
            n_fail++;
            $display("FAIL b2b_accept_spacing: got %0d required 11", a2 - a1);
        end
    endtask

    task automatic test_prod();
        int a, o;
        send(p3(16'hFFFF, 16'h0000, 16'h0000), p3(16'hFFFF, 16'h0000, 16'h0000), map_ri(), 1'b0, a);
        collect("prod", 0, 1'b0, o);
`ifdef FUZZY_PROD_AND_EN
        n_checks++;
        if (w_cons[0 +: W] !== 16'hFFFE || w_max !== 16'hFFFE || win_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL prod_const: w_cons0=%h w_max=%h idx=%0d required FFFE FFFE 0",
                     w_cons[0 +: W], w_max, win_idx);
        end
`endif
    endtask

    task automatic test_random();
        int a, o;
        logic [NT*W-1:0]  mt;
        logic [ND*W-1:0]  md;
        logic [NR*CW-1:0] mp;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < NT; i++) mt[i*W +: W] = W'($urandom);
            for (int j = 0; j < ND; j++) md[j*W +: W] = W'($urandom);
            for (int r = 0; r < NR; r++) mp[r*CW +: CW] = CW'($urandom_range(0, 3));
            if (t == 0) md[0 +: W] = '0;
            send(mt, md, mp, 1'b0, a);
            collect("random", 0, 1'b0, o);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_min();
        test_tie_ignored();
        test_backpressure();
        test_back_to_back();
        test_prod();
        test_random();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fuzzy_rules_seq.md
Name: fuzzy_rules_seq

Overview:
Parametrised, sequential successor to the 2x2 min-AND rule block. Takes NT temperature and ND delta membership degrees and evaluates the full NT x ND rule grid, one rule per cycle. Each rule strength is AND(muT[i], muD[j]). It is max-aggregated into NC consequent classes through a runtime rule map. The block sits between the fuzzifiers and the defuzzifier, with valid/ready handshakes on both sides.

Parameters:
W, 16, bit width of membership degrees and strengths (unsigned, full scale = 2^W-1)
NT, 3, number of temperature membership functions
ND, 3, number of delta membership functions
NC, 3, number of consequent classes
CW, $clog2(NC) (min 1), width of one rule-map entry (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input bundle valid
in_ready  out  1  block can accept input
muT  in  NT*W  temperature degrees; slice i = bits [i*W +: W]
muD  in  ND*W  delta degrees; slice j = bits [j*W +: W]
rule_map  in  NT*ND*CW  consequent class of rule r=i*ND+j, slice [r*CW +: CW]; sampled at accept
out_valid  out  1  aggregated result valid
out_ready  in  1  downstream accepts result
w_cons  out  NC*W  aggregated strength per class; slice k = [k*W +: W]
w_max  out  W  strongest single rule strength
win_idx  out  $clog2(NT*ND)  index r of strongest rule
busy  out  1  high in EVAL or DONE

Behaviour:
- States: IDLE, EVAL, DONE. Reset -> IDLE.
- Reset values: in_ready=1, out_valid=0, busy=0, w_cons=0, w_max=0, win_idx=0, rule counter=0, latched inputs=0.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch muT, muD, rule_map; clear accumulators, w_max and win_idx to 0; set r=0; go to EVAL.
- EVAL:
  - in_ready=0; inputs are ignored.
  - Each cycle evaluates rule r (i=r/ND, j=r%ND): s = AND(muT[i], muD[j]).
    - Default AND is unsigned min.
  - If map[r] < NC: acc[map[r]] <= max(acc[map[r]], s).
  - If map[r] >= NC: the rule is ignored for aggregation, but still competes for w_max/win_idx.
  - If s > w_max (strict): w_max <= s, win_idx <= r. Ties keep the lower index.
  - After r = NT*ND-1: go to DONE.
  - Evaluation order is r = 0, 1, ..., NT*ND-1.
- DONE:
  - out_valid=1; w_cons, w_max and win_idx are stable.
  - On out_ready: out_valid <= 0, go to IDLE.
  - Outputs keep their last values in IDLE until the next accept clears them.
  - A new accept is possible in the cycle after the out handshake.
- Latency: accept at cycle 0 -> out_valid high at cycle NT*ND+1.
- Throughput: one bundle per NT*ND+2 cycles when out_ready is held high.
- All comparisons are unsigned. Max/min never overflow, so no saturation is needed.
- Zero-degree rules leave the accumulators unchanged.
- Reset asserted mid-EVAL or mid-DONE aborts immediately to the reset values. No partial result is ever flagged valid.
- out_ready while not in DONE is ignored. in_valid outside IDLE is ignored; upstream must hold the bundle until in_ready.

Optional Feature:
FUZZY_PROD_AND_EN:
- Defined: the AND operator becomes the algebraic product, s = (muT[i]*muD[j]) >> W, computed at 2W bits and truncated.
  - Example: 0xFFFF*0xFFFF -> 0xFFFE.
  - Latency is unchanged; the product is combinational within the EVAL cycle.
- Undefined: AND = min. No multiplier is inferred.

Test Plan:
- Reset then idle: rst_n low mid-EVAL -> out_valid=0, in_ready=1, w_cons=0, w_max=0, win_idx=0 immediately.
- Basic min, NT=ND=NC=3, map r->i:
  - Stimulus: muT={0x8000,0x4000,0x0000}, muD={0x6000,0xFFFF,0x0000}.
  - Required: out_valid at cycle 10 after accept; w_cons={0x8000,0x4000,0x0000}; w_max=0x8000; win_idx=1.
- Tie and ignored rule:
  - Stimulus: all muT=muD=0x1234; map[0]=3 (>=NC), others map to 0.
  - Required: w_cons={0x1234,0,0}, w_max=0x1234, win_idx=0.
- Backpressure:
  - Stimulus: out_ready=0 for 20 cycles after out_valid; in_valid held with a new bundle.
  - Required: outputs stable, in_ready=0 throughout; new bundle accepted 1 cycle after the out handshake.
- Back-to-back:
  - Stimulus: two bundles, in_valid and out_ready always 1.
  - Required: second out_valid exactly 11 cycles after the first; the second result is independent of the first (accumulators cleared).
- FUZZY_PROD_AND_EN:
  - Stimulus: muT[0]=muD[0]=0xFFFF, rest 0, map r->i.
  - Required: w_cons[0]=0xFFFE, w_max=0xFFFE, win_idx=0.
